bsg_manycore_wrap_link_rx: RTL and testbench

//  - Receive end of the credit-flow-controlled torus wrap-around link between the east and west edges of a compute subarray.
//  - The far-end transmitter launches a word down a pipelined long wire only when it holds a credit.
//  - This block buffers arriving words, presents them to the edge tile as a valid/yumi stream, and returns one credit per word consumed.
//  - One instance sits at each row's west edge, on both fwd and rev channels.

---
 rtl/bsg_manycore_wrap_link_rx.sv | 121 ++++++++++++
 tb/tb_bsg_manycore_wrap_link_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_wrap_link_rx.sv
// bsg_manycore_wrap_link_rx
//   Receive end of the credit-flow-controlled torus wrap-around link. Words that
//   arrive from the long wrap wire are queued in a circular buffer. The queue
//   head is presented to the edge tile as a valid/yumi stream. One credit pulse
//   goes back to the far-end transmitter for every word that is consumed.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous active-high reset; drops all buffered words
//   v_i/data_i  word arriving from the wrap wire
//   credit_o    one-cycle pulse, one credit returned, issued the cycle after a yumi
//   v_o/data_o  buffer head valid / payload
//   yumi_i      consumer takes the head this cycle (legal only while v_o=1)
//   count_o     current occupancy
//   overflow_o  sticky protocol error: a word arrived while the buffer was full

module bsg_manycore_wrap_link_rx #(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int lg_els_lp = $clog2(els_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 v_i,
    input  logic [width_p-1:0]   data_i,
    output logic                 credit_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    input  logic                 yumi_i,
    output logic [lg_els_lp-1:0] count_o,
    output logic                 overflow_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp-1:0]  last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [lg_els_lp-1:0] full_cnt_lp = lg_els_lp'(els_p);

    logic [width_p-1:0]   mem_q [els_p];
    logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
    logic [lg_els_lp-1:0] count_q, count_d;
    logic                 credit_q, credit_d;
    logic                 overflow_q, overflow_d;

    logic full, empty, enq, deq;

    assign full  = (count_q == full_cnt_lp);
    assign empty = (count_q == '0);
    // A full buffer rejects the incoming word even when the head is consumed
    // in the same cycle. The slot that the dequeue frees is usable only on the next cycle.
    assign enq   = v_i & ~full;
    // A yumi while the buffer is empty is ignored, so the state stays consistent.
    assign deq   = yumi_i & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = deq;
        overflow_d = overflow_q | (v_i & full);

        // Pointers wrap explicitly because els_p need not be a power of two.
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + lg_els_lp'(1);
            2'b01:   count_d = count_q - lg_els_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // The payload storage has no reset. Entries are only read after they have been written.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign v_o        = ~empty;
    assign data_o     = mem_q[rd_ptr_q];
    assign credit_o   = credit_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

`ifndef SYNTHESIS
    if (els_p < 2) begin : g_els_chk
        $error("bsg_manycore_wrap_link_rx: els_p must be >= 2");
    end

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!$isunknown(v_i) && !$isunknown(yumi_i))
                else $error("bsg_manycore_wrap_link_rx: v_i/yumi_i unknown");
            assert (!yumi_i || v_o)
                else $error("bsg_manycore_wrap_link_rx: yumi_i while empty");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_wrap_link_rx.sv
module tb_bsg_manycore_wrap_link_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance with the default depth of 4.
    logic       v4, yumi4, credit4, vo4, ovf4;
    logic [7:0] d4, do4;
    logic [2:0] cnt4;

    // Instance with a depth of 3, used for the wrap and random traffic.
    logic       v3, yumi3, credit3, vo3, ovf3;
    logic [7:0] d3, do3;
    logic [1:0] cnt3;

    bsg_manycore_wrap_link_rx #(.width_p(8), .els_p(4)) dut4 (
        .clk_i(clk), .reset_i(reset), .v_i(v4), .data_i(d4),
        .credit_o(credit4), .v_o(vo4), .data_o(do4), .yumi_i(yumi4),
        .count_o(cnt4), .overflow_o(ovf4)
    );

    bsg_manycore_wrap_link_rx #(.width_p(8), .els_p(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .v_i(v3), .data_i(d3),
        .credit_o(credit3), .v_o(vo3), .data_o(do3), .yumi_i(yumi3),
        .count_o(cnt3), .overflow_o(ovf3)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp4 [4] = '{8'hB2, 8'hB3, 8'hB4, 8'hB6};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives the depth-3 instance. A transmitter model starts with 3 credits,
    // and a consumer issues random yumis. A scoreboard checks the order of the
    // delivered words. The conservation check runs every cycle and compares
    // the words sent minus the credit pulses seen before this cycle with
    // count_o plus the pulse that is pending now.
    task automatic run_random(input int n, input int max_cycles, input string tag);
        logic [7:0] q [$];
        int tx_cred = 3;
        int sent = 0, got = 0, crd = 0, cyc = 0;
        while (got < n && cyc < max_cycles) begin
            v3    = 1'b0;
            yumi3 = 1'b0;
            if (sent < n && tx_cred > 0 && $urandom_range(0, 3) != 0) begin
                v3 = 1'b1;
                d3 = 8'($urandom_range(0, 255));
                q.push_back(d3);
                sent++;
                tx_cred--;
            end
            if (vo3 && $urandom_range(0, 2) != 0) begin
                yumi3 = 1'b1;
                chk({tag, "_data"}, {24'h0, do3}, {24'h0, q.pop_front()});
                got++;
            end
            tick();
            cyc++;
            chk({tag, "_conserve"}, 32'(sent - crd), 32'(cnt3) + 32'(credit3));
            chk({tag, "_ovf"}, {31'h0, ovf3}, 32'h0);
            if (credit3) begin
                crd++;
                tx_cred++;
            end
        end
        v3    = 1'b0;
        yumi3 = 1'b0;
        chk({tag, "_all_delivered"}, 32'(got), 32'(n));
        chk({tag, "_credits"}, 32'(crd), 32'(n));
        tick();
        chk({tag, "_final_count"}, {30'h0, cnt3}, 32'h0);
        chk({tag, "_final_v"}, {31'h0, vo3}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        v4 = 1'b0; yumi4 = 1'b0; d4 = '0;
        v3 = 1'b0; yumi3 = 1'b0; d3 = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_v", {31'h0, vo4}, 32'h0);
            chk("idle_credit", {31'h0, credit4}, 32'h0);
            chk("idle_count", {29'h0, cnt4}, 32'h0);
            chk("idle_ovf", {31'h0, ovf4}, 32'h0);
        end
        chk("idle_count3", {30'h0, cnt3}, 32'h0);

        // 2: stream 0x11, 0x22, 0x33 with the consumer always ready
        v4 = 1'b1; d4 = 8'h11; yumi4 = 1'b0;
        tick();
        chk("s_v1", {31'h0, vo4}, 32'h1);
        chk("s_d1", {24'h0, do4}, 32'h11);
        chk("s_cr1", {31'h0, credit4}, 32'h0);
        d4 = 8'h22; yumi4 = 1'b1;
        tick();
        chk("s_d2", {24'h0, do4}, 32'h22);
        chk("s_cr2", {31'h0, credit4}, 32'h1);
        chk("s_cnt2", {29'h0, cnt4}, 32'h1);
        d4 = 8'h33; yumi4 = 1'b1;
        tick();
        chk("s_d3", {24'h0, do4}, 32'h33);
        chk("s_cr3", {31'h0, credit4}, 32'h1);
        v4 = 1'b0; yumi4 = 1'b1;
        tick();
        chk("s_v_end", {31'h0, vo4}, 32'h0);
        chk("s_cr4", {31'h0, credit4}, 32'h1);
        chk("s_cnt_end", {29'h0, cnt4}, 32'h0);
        yumi4 = 1'b0;
        tick();
        chk("s_cr_off", {31'h0, credit4}, 32'h0);

        // 3: fill to 4, then a fifth word overflows
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; d4 = 8'hA1 + 8'(i);
            tick();
            chk("fill_count", {29'h0, cnt4}, 32'(i + 1));
            chk("fill_credit", {31'h0, credit4}, 32'h0);
        end
        d4 = 8'hA5;
        tick();
        chk("ovf_set", {31'h0, ovf4}, 32'h1);
        chk("ovf_count", {29'h0, cnt4}, 32'h4);
        chk("ovf_head", {24'h0, do4}, 32'hA1);
        v4 = 1'b0;
        tick();
        chk("ovf_sticky", {31'h0, ovf4}, 32'h1);
        chk("ovf_head2", {24'h0, do4}, 32'hA1);

        // 4: full, then enqueue and dequeue in the same cycle
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_ovf_clr", {31'h0, ovf4}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; d4 = 8'hB1 + 8'(i);
            tick();
        end
        chk("full_count", {29'h0, cnt4}, 32'h4);
        v4 = 1'b1; d4 = 8'hB5; yumi4 = 1'b1;
        tick();
        chk("fe_ovf", {31'h0, ovf4}, 32'h1);
        chk("fe_count", {29'h0, cnt4}, 32'h3);
        chk("fe_credit", {31'h0, credit4}, 32'h1);
        chk("fe_head", {24'h0, do4}, 32'hB2);
        v4 = 1'b1; d4 = 8'hB6; yumi4 = 1'b0;
        tick();
        chk("refill_count", {29'h0, cnt4}, 32'h4);
        chk("refill_credit", {31'h0, credit4}, 32'h0);
        v4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_v", {31'h0, vo4}, 32'h1);
            chk("drain_data", {24'h0, do4}, {24'h0, exp4[i]});
            yumi4 = 1'b1;
            tick();
            yumi4 = 1'b0;
        end
        chk("drain_count", {29'h0, cnt4}, 32'h0);
        chk("drain_credit", {31'h0, credit4}, 32'h1);
        tick();

        // 6: reset with 2 words buffered and a credit pending
        for (int i = 0; i < 3; i++) begin
            v4 = 1'b1; d4 = 8'hC1 + 8'(i);
            tick();
        end
        v4 = 1'b0; yumi4 = 1'b1;
        tick();
        yumi4 = 1'b0;
        chk("pre_rst_count", {29'h0, cnt4}, 32'h2);
        chk("pre_rst_credit", {31'h0, credit4}, 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_rst_count", {29'h0, cnt4}, 32'h0);
        chk("mid_rst_v", {31'h0, vo4}, 32'h0);
        chk("mid_rst_credit", {31'h0, credit4}, 32'h0);
        chk("mid_rst_ovf", {31'h0, ovf4}, 32'h0);
        reset = 1'b0;

        // 5: 10 words through the depth-3 buffer, crossing the pointer wrap
        run_random(10, 300, "wrap");

        // long random traffic with the transmitter model
        reset = 1'b1; tick(); reset = 1'b0;
        run_random(3000, 12000, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
